// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: command-driven load/shift/rotate controller for a 4-bit shift register
//   host side : cmd_valid/cmd_ready handshake, cmd_data/dir/rot/sin/count, busy, done, result
//   reg side  : ENB, DIR, S_IN, MODO, D out; Q, S_OUT in
//   define SHIFT_SEQ_ABORT_EN to add the abort input and aborted output
module shift_reg_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic             cmd_rot,
  input  logic             cmd_sin,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             ENB,
  output logic             DIR,
  output logic             S_IN,
  output logic [1:0]       MODO,
  output logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q,
  input  logic             S_OUT,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             rot;
  logic             abort_req;
  logic             unused_s_out;
  logic             finish;
  assign unused_s_out = S_OUT;
`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif
  // RUN exits after the cycle where the counter reads zero; LOAD skips RUN for count 0
  assign finish = abort_req || (state == LOAD ? cnt == '0 : cnt == '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      ENB       <= 1'b0;
      MODO      <= 2'b00;
      DIR       <= 1'b0;
      S_IN      <= 1'b0;
      D         <= '0;
      result    <= '0;
      cnt       <= '0;
      rot       <= 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
      aborted <= 1'b0;
`endif
      case (state)
        IDLE: if (cmd_valid) begin
          state     <= LOAD;
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          ENB       <= 1'b1;
          MODO      <= 2'b10;
          D         <= cmd_data;
          DIR       <= cmd_dir;
          S_IN      <= cmd_sin;
          rot       <= cmd_rot;
          cnt       <= cmd_count;
        end
        LOAD, RUN: if (finish) begin
          state <= DONE;
          ENB   <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
`ifdef SHIFT_SEQ_ABORT_EN
          aborted <= abort_req;
`endif
        end else begin
          state <= RUN;
          MODO  <= {1'b0, rot};
          cnt   <= cnt - 1'b1;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          result    <= Q;
        end
      endcase
    end
  end
endmodule
